// File: rtl/color_sequencer_pkg.sv
// Shared definitions for the colour sequencer: mode encodings, FSM states,
// the eight named colour codes and small decode helpers.
package color_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE     = 2'b00,
        MODE_AUTO     = 2'b01,
        MODE_MANUAL   = 2'b10,
        MODE_PINGPONG = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_AUTO    = 3'd1,
        ST_MANUAL  = 3'd2,
        ST_PP_UP   = 3'd3,
        ST_PP_DOWN = 3'd4
    } state_e;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    function automatic logic [2:0] color_code(input logic [2:0] lo);
        case (lo)
            3'd0:    color_code = BLACK;
            3'd1:    color_code = BLUE;
            3'd2:    color_code = GREEN;
            3'd3:    color_code = CYAN;
            3'd4:    color_code = RED;
            3'd5:    color_code = MAGENTA;
            3'd6:    color_code = YELLOW;
            3'd7:    color_code = WHITE;
            default: color_code = BLACK;
        endcase
    endfunction

    // Both ping-pong directions belong to the single PINGPONG mode.
    function automatic logic [1:0] state_mode(input state_e st);
        case (st)
            ST_IDLE:              state_mode = MODE_IDLE;
            ST_AUTO:              state_mode = MODE_AUTO;
            ST_MANUAL:            state_mode = MODE_MANUAL;
            ST_PP_UP, ST_PP_DOWN: state_mode = MODE_PINGPONG;
            default:              state_mode = MODE_IDLE;
        endcase
    endfunction

    function automatic state_e mode_entry(input logic [1:0] m);
        case (m)
            MODE_IDLE:     mode_entry = ST_IDLE;
            MODE_AUTO:     mode_entry = ST_AUTO;
            MODE_MANUAL:   mode_entry = ST_MANUAL;
            MODE_PINGPONG: mode_entry = ST_PP_UP;
            default:       mode_entry = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/color_sequencer_dwell_timer.sv
// Dwell counter: counts 0..dwell, raising terminal once count reaches dwell
// (or exceeds it after dwell was lowered) and self-clearing on the next count.
module dwell_timer #(
    parameter int DWELL_W = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    output logic               terminal
);

    logic [DWELL_W-1:0] count_r;

    assign terminal = (count_r >= dwell);

    // Counter update: clear has priority over counting; disabled holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {DWELL_W{1'b0}};
        end else if (clr) begin
            count_r <= {DWELL_W{1'b0}};
        end else if (en) begin
            if (terminal) begin
                count_r <= {DWELL_W{1'b0}};
            end else begin
                count_r <= count_r + {{(DWELL_W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/color_sequencer.sv
// Colour index sequencer with AUTO, MANUAL and PINGPONG stepping; index,
// one-hot select, RGB code and wrap pulse are all registered together.
module color_sequencer #(
    parameter int N_COLORS = 8,
    parameter int DWELL_W  = 20,
    parameter int IDX_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                step,
    input  logic [DWELL_W-1:0]  dwell,
    output logic [IDX_W-1:0]    color_idx,
    output logic [N_COLORS-1:0] color_sel,
    output logic [2:0]          rgb,
    output logic                wrap
);
    import color_sequencer_pkg::*;

    localparam logic [IDX_W-1:0]    IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]    IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_COLORS - 1);
    localparam logic [N_COLORS-1:0] SEL_BIT0 = {{(N_COLORS-1){1'b0}}, 1'b1};

    state_e               state_r;
    state_e               state_nxt_s;
    logic                 step_q_r;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     idx_nxt_s;
    logic [IDX_W-1:0]     idx_inc_s;
    logic [IDX_W-1:0]     idx_dec_s;
    logic [N_COLORS-1:0]  sel_r;
    logic [2:0]           rgb_r;
    logic                 wrap_r;
    logic                 wrap_nxt_s;
    logic                 mode_change_s;
    logic                 step_rise_s;
    logic                 timed_state_s;
    logic                 timer_en_s;
    logic                 timer_clr_s;
    logic                 terminal_s;

    assign mode_change_s = (mode != state_mode(state_r));
    assign step_rise_s   = step & ~step_q_r;
    assign idx_inc_s     = (idx_r == IDX_LAST) ? IDX_ZERO : idx_r + IDX_ONE;
    assign idx_dec_s     = idx_r - IDX_ONE;
    assign timed_state_s = (state_r == ST_AUTO) || (state_r == ST_PP_UP) || (state_r == ST_PP_DOWN);
    // A pending mode change clears the timer instead of letting it count.
    assign timer_en_s    = en & ~mode_change_s & timed_state_s;
    assign timer_clr_s   = en & (mode_change_s | ~timed_state_s);

    dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (timer_clr_s),
        .en       (timer_en_s),
        .dwell    (dwell),
        .terminal (terminal_s)
    );

    // Next state, next index and wrap decision; a mode change beats any advance.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        wrap_nxt_s  = 1'b0;
        if (!en) begin
            state_nxt_s = state_r;
        end else if (mode_change_s) begin
            state_nxt_s = mode_entry(mode);
            if (mode == MODE_IDLE) begin
                idx_nxt_s = IDX_ZERO;
            end else begin
                idx_nxt_s = idx_r;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    idx_nxt_s = IDX_ZERO;
                end
                ST_AUTO: begin
                    if (terminal_s) begin
                        idx_nxt_s  = idx_inc_s;
                        wrap_nxt_s = (idx_inc_s == IDX_ZERO);
                    end else begin
                        idx_nxt_s = idx_r;
                    end
                end
                ST_MANUAL: begin
                    if (step_rise_s) begin
                        idx_nxt_s  = idx_inc_s;
                        wrap_nxt_s = (idx_inc_s == IDX_ZERO);
                    end else begin
                        idx_nxt_s = idx_r;
                    end
                end
                ST_PP_UP: begin
                    if (!terminal_s) begin
                        idx_nxt_s = idx_r;
                    end else if (idx_r == IDX_LAST) begin
                        idx_nxt_s   = idx_dec_s;
                        wrap_nxt_s  = (idx_dec_s == IDX_ZERO);
                        state_nxt_s = ST_PP_DOWN;
                    end else begin
                        idx_nxt_s   = idx_r + IDX_ONE;
                        wrap_nxt_s  = (idx_r + IDX_ONE == IDX_LAST);
                        state_nxt_s = (idx_r + IDX_ONE == IDX_LAST) ? ST_PP_DOWN : ST_PP_UP;
                    end
                end
                ST_PP_DOWN: begin
                    if (!terminal_s) begin
                        idx_nxt_s = idx_r;
                    end else if (idx_r == IDX_ZERO) begin
                        idx_nxt_s   = idx_r + IDX_ONE;
                        wrap_nxt_s  = (idx_r + IDX_ONE == IDX_LAST);
                        state_nxt_s = ST_PP_UP;
                    end else begin
                        idx_nxt_s   = idx_dec_s;
                        wrap_nxt_s  = (idx_dec_s == IDX_ZERO);
                        state_nxt_s = (idx_dec_s == IDX_ZERO) ? ST_PP_UP : ST_PP_DOWN;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = IDX_ZERO;
                end
            endcase
        end
    end

    // FSM and output registers; step history keeps tracking even while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            step_q_r <= 1'b0;
            idx_r    <= IDX_ZERO;
            sel_r    <= SEL_BIT0;
            rgb_r    <= BLACK;
            wrap_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            step_q_r <= step;
            idx_r    <= idx_nxt_s;
            sel_r    <= SEL_BIT0 << idx_nxt_s;
            rgb_r    <= color_code(3'(idx_nxt_s));
            wrap_r   <= wrap_nxt_s;
        end
    end

    assign color_idx = idx_r;
    assign color_sel = sel_r;
    assign rgb       = rgb_r;
    assign wrap      = wrap_r;

endmodule

// File: tb/tb_color_sequencer.sv
// Directed bench for color_sequencer: inputs driven and outputs sampled on the
// falling edge, expected values computed by hand or by simple formulas.
module tb_color_sequencer;
    import color_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  mode;
    logic        step;
    logic [19:0] dwell;
    logic [2:0]  color_idx;
    logic [7:0]  color_sel;
    logic [2:0]  rgb;
    logic        wrap;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    color_sequencer #(.N_COLORS(8), .DWELL_W(20), .IDX_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .step      (step),
        .dwell     (dwell),
        .color_idx (color_idx),
        .color_sel (color_sel),
        .rgb       (rgb),
        .wrap      (wrap)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_out(input string tag, input int exp_idx, input logic exp_wrap);
        check_eq({tag, "_idx"},  32'(color_idx), 32'(exp_idx));
        check_eq({tag, "_sel"},  32'(color_sel), 32'd1 << exp_idx);
        check_eq({tag, "_rgb"},  32'(rgb),       32'(exp_idx));
        check_eq({tag, "_wrap"}, 32'(wrap),      32'(exp_wrap));
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        mode  = MODE_AUTO;
        step  = 1'b0;
        dwell = 20'd3;
        cyc(2);
        check_out("reset", 0, 1'b0);

        // AUTO dwell=3: each index held 4 cycles, then wrap back to 0
        reset = 1'b0;
        for (int k = 0; k < 32; k++) begin
            cyc(1);
            check_out("auto3", k / 4, 1'b0);
        end
        cyc(1);
        check_out("auto3_wrap", 0, 1'b1);
        cyc(1);
        check_out("auto3_after", 0, 1'b0);

        // AUTO dwell=0: advance every cycle
        dwell = 20'd0;
        for (int j = 0; j < 16; j++) begin
            cyc(1);
            check_out("auto0", (j + 1) % 8, ((j + 1) % 8) == 0);
        end

        // mode change coinciding with terminal count: no advance
        mode = MODE_MANUAL;
        cyc(1);
        check_out("modechg_wins", 0, 1'b0);

        step = 1'b1;
        cyc(1);
        check_out("man_rise", 1, 1'b0);
        cyc(9);
        check_out("man_held", 1, 1'b0);
        step = 1'b0;
        cyc(2);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(2);
        check_out("man_pulse1", 2, 1'b0);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(2);
        check_out("man_pulse2", 3, 1'b0);

        // step edge while disabled must not fire on re-enable
        en   = 1'b0;
        step = 1'b1;
        cyc(2);
        check_out("man_dis", 3, 1'b0);
        en = 1'b1;
        cyc(2);
        check_out("man_stale", 3, 1'b0);
        step = 1'b0;

        mode = MODE_IDLE;
        cyc(1);
        check_out("idle", 0, 1'b0);

        // PINGPONG dwell=1: 0..7..0, each held 2 cycles, wrap on each endpoint
        mode  = MODE_PINGPONG;
        dwell = 20'd1;
        for (int m = 0; m < 32; m++) begin
            int u;
            int e;
            cyc(1);
            u = (m / 2) % 14;
            e = (u <= 7) ? u : 14 - u;
            check_out("pp", e, (m % 2 == 0) && (m > 0) && (u == 7 || u == 0));
        end

        // AUTO dwell=9, lower dwell to 2 at timer=6
        mode  = MODE_AUTO;
        dwell = 20'd9;
        cyc(1);
        check_out("a9_enter", 1, 1'b0);
        cyc(6);
        check_out("a9_mid", 1, 1'b0);
        dwell = 20'd2;
        cyc(1);
        check_out("dwell_lower", 2, 1'b0);
        cyc(1);
        check_out("pre_freeze", 2, 1'b0);
        en = 1'b0;
        cyc(5);
        check_out("frozen", 2, 1'b0);
        en = 1'b1;
        cyc(1);
        check_out("thaw", 2, 1'b0);
        cyc(1);
        check_out("thaw_adv", 3, 1'b0);

        // reset mid-AUTO at idx 5, overriding en=0
        dwell = 20'd0;
        cyc(2);
        check_out("pre_reset", 5, 1'b0);
        reset = 1'b1;
        en    = 1'b0;
        cyc(1);
        check_out("rst_mid", 0, 1'b0);
        reset = 1'b0;
        en    = 1'b1;
        cyc(1);
        check_out("rst_idle_enter", 0, 1'b0);
        cyc(1);
        check_out("rst_first_adv", 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/color_sequencer.md
COLOR_SEQUENCER -- requirements
Module: color_sequencer

Interface
REQ-001 Parameter N_COLORS, default 8, number of colours in the sequence (2..256).
REQ-002 Parameter DWELL_W, default 20, width of dwell counter and dwell input.
REQ-003 Parameter IDX_W, default 3, width of colour index; SHALL equal ceil(log2(N_COLORS)).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  global enable; 0 freezes timer, index, direction.
REQ-007 mode  input  2  00 IDLE, 01 AUTO, 10 MANUAL, 11 PINGPONG.
REQ-008 step  input  1  level input; rising edge advances index in MANUAL.
REQ-009 dwell  input  DWELL_W  terminal count; colour held dwell+1 cycles.
REQ-010 color_idx  output  IDX_W  current colour index, registered.
REQ-011 color_sel  output  N_COLORS  one-hot of color_idx, registered.
REQ-012 rgb  output  3  color_idx[2:0] when N_COLORS=8 (000 Black ... 111 White); else low 3 bits of color_idx.
REQ-013 wrap  output  1  one-cycle pulse in the cycle color_idx returns to 0 (AUTO/MANUAL) or reverses direction (PINGPONG).

Function
REQ-014 Outputs SHALL be registered; color_sel, rgb, color_idx SHALL change in the same cycle.
REQ-015 State machine SHALL have states IDLE, AUTO, MANUAL, PP_UP, PP_DOWN; state tracks mode, PINGPONG entered as PP_UP.
REQ-016 IDLE: color_idx forced to 0, timer held at 0, wrap 0.
REQ-017 AUTO: timer counts 0..dwell; in the cycle timer==dwell, timer clears and index advances by 1, visible next cycle.
REQ-018 Index SHALL wrap N_COLORS-1 -> 0, never reaching N_COLORS; wrap pulses with the 0 value.
REQ-019 dwell=0 SHALL advance the index every enabled cycle.
REQ-020 If dwell is lowered below current timer value, advance SHALL occur on the next enabled cycle (timer>=dwell treated as terminal).
REQ-021 MANUAL: timer unused; each 0->1 transition of step (registered edge detect) advances index once; held high gives one advance.
REQ-022 PINGPONG: PP_UP increments to N_COLORS-1 then moves to PP_DOWN; PP_DOWN decrements to 0 then moves to PP_UP; endpoints held dwell+1 cycles once; wrap pulses on arrival at each endpoint.
REQ-023 Any mode change SHALL clear timer to 0 and keep color_idx (except into IDLE); step edges in non-MANUAL modes ignored.
REQ-024 en=0 SHALL freeze all state; step edge detector still updates so no stale edge fires on re-enable.
REQ-025 Simultaneous terminal count and mode change: mode change wins, no advance.

Reset
REQ-026 On reset: color_idx=0, color_sel=1 (bit 0), rgb=000, wrap=0, timer=0, state=IDLE, step history=0.
REQ-027 reset SHALL override en and any in-progress dwell; first advance after release requires full dwell+1 cycles.

Structure
REQ-028 Shared package SHALL hold mode encodings, state enumeration and the 8 named colour codes (BLACK=000 ... WHITE=111).
REQ-029 One sub-module, dwell_timer (DWELL_W counter with clear, enable, terminal flag), SHALL be instantiated; rest in color_sequencer.

Verification
REQ-030 Reset, mode=AUTO, dwell=3, en=1 -> idx 0 for 4 cycles, then 1,2..7 each 4 cycles, then 0 with wrap=1 one cycle; color_sel one-hot each step.
REQ-031 AUTO dwell=0 -> idx increments every cycle, wrap every 8 cycles; rgb matches idx.
REQ-032 MANUAL, step high 10 cycles then low, then two 1-cycle pulses -> idx 0->1->2->3, exactly three advances.
REQ-033 PINGPONG dwell=1 -> idx 0..7..0 sequence each held 2 cycles, wrap at 7 and at 0, no repeated endpoint.
REQ-034 AUTO dwell=9, at timer=6 set dwell=2 -> advance next cycle; en=0 for 5 cycles mid-dwell -> idx, timer frozen.
REQ-035 Reset asserted mid-AUTO at idx=5 -> next cycle idx=0, color_sel=1, rgb=000, state IDLE.
